// File: rtl/unpacker_frame.sv
// unpacker_frame
//   Splits each accepted packed word into up to PackedNum elements of
//   UnpackedWidth bits. Every word carries its own element count, so words
//   may be partial. The frame-end flag is attached to the final element, and
//   back-to-back words stream out without an idle cycle.
//
// Ports
//   clk_i       clock, all state on rising edge
//   rst_ni      asynchronous active-low reset
//   packed_i    packed input word (PackedWidth bits)
//   count_i     number of valid elements in packed_i (0 or >PackedNum = full word)
//   last_i      packed_i ends a frame
//   valid_i     input valid
//   ready_o     input ready (combinational from ready_i only)
//   unpacked_o  current element, 0 while idle
//   last_o      unpacked_o is the final element of a frame
//   valid_o     output valid
//   ready_i     downstream ready
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no word held; ready_o=1, valid_o=0
// EMIT  | word held; presenting element idx_q, last element at last_idx_q

module unpacker_frame #(
  parameter int UnpackedWidth = 2,
  parameter int PackedNum     = 4,
  parameter bit MsbFirst      = 1'b0,
  parameter int PackedWidth   = UnpackedWidth * PackedNum,
  parameter int CountWidth    = $clog2(PackedNum + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [PackedWidth-1:0]   packed_i,
  input  logic [CountWidth-1:0]    count_i,
  input  logic                     last_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [UnpackedWidth-1:0] unpacked_o,
  output logic                     last_o,
  output logic                     valid_o,
  input  logic                     ready_i
);

  localparam int IdxWidth = $clog2(PackedNum);

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  state_e                   state_q;
  logic [PackedWidth-1:0]   word_q;
  logic [IdxWidth-1:0]      idx_q;
  logic [IdxWidth-1:0]      last_idx_q;
  logic                     frame_q;

  logic                     busy;
  logic                     final_elem;
  logic                     in_fire;
  logic                     out_fire;
  logic [IdxWidth-1:0]      last_idx_d;
  logic [UnpackedWidth-1:0] slice;

  assign busy       = (state_q == EMIT);
  assign final_elem = (idx_q == last_idx_q);
  assign out_fire   = busy && ready_i;
  // A new word is taken on the same edge the final element leaves, which is
  // what keeps back-to-back words bubble-free.
  assign ready_o    = !busy || (out_fire && final_elem);
  assign in_fire    = valid_i && ready_o;

  // Store the index of the final element rather than the count itself;
  // a zero or oversized count means a full word.
  always_comb begin
    last_idx_d = IdxWidth'(PackedNum - 1);
    if ((count_i != '0) && (count_i <= CountWidth'(PackedNum))) begin
      last_idx_d = IdxWidth'(count_i - CountWidth'(1));
    end
  end

  always_comb begin
    slice = '0;
    for (int k = 0; k < PackedNum; k++) begin
      if (idx_q == IdxWidth'(k)) begin
        slice = word_q[(MsbFirst ? (PackedNum - 1 - k) : k) * UnpackedWidth +: UnpackedWidth];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      frame_q    <= 1'b0;
    end else begin
      if (in_fire) begin
        state_q    <= EMIT;
        word_q     <= packed_i;
        idx_q      <= '0;
        last_idx_q <= last_idx_d;
        frame_q    <= last_i;
      end else if (out_fire) begin
        if (final_elem) begin
          state_q <= IDLE;
          idx_q   <= '0;
        end else begin
          idx_q <= idx_q + IdxWidth'(1);
        end
      end
    end
  end

  assign valid_o    = busy;
  assign unpacked_o = busy ? slice : '0;
  assign last_o     = busy && frame_q && final_elem;

endmodule

// File: doc/unpacker_frame.md
Name: unpacker_frame

Overview:
Parametrised successor to the fixed-ratio unpacker. Splits each accepted packed word into up to PackedNum elements of UnpackedWidth bits, with these additions:
- per-word element count, so partial words are supported
- selectable element order (LSB-first or MSB-first)
- frame-end marker propagated to the final element
- zero-bubble streaming across back-to-back words
Sits between a packed bus (e.g. camera/DMA word stream) and per-pixel processing blocks.

Parameters:
UnpackedWidth, 2, bits per output element (>=1)
PackedNum, 4, maximum elements per packed word (>=2)
MsbFirst, 0, 0: element 0 = bits [UnpackedWidth-1:0]; 1: element 0 = most-significant slice
PackedWidth, UnpackedWidth*PackedNum, derived; input word width
CountWidth, $clog2(PackedNum+1), derived; width of count_i

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
packed_i  input  PackedWidth  packed word
count_i  input  CountWidth  number of valid elements in packed_i
last_i  input  1  packed_i ends a frame
valid_i  input  1  input valid
ready_o  output  1  input ready
unpacked_o  output  UnpackedWidth  current element
last_o  output  1  unpacked_o is the final element of a frame
valid_o  output  1  output valid
ready_i  input  1  downstream ready

Behaviour:
- Reset (rst_ni low, asynchronous, any cycle including mid-word):
  - word buffer, element index, count and frame flag cleared; busy=0
  - valid_o=0, unpacked_o=0, last_o=0, ready_o=1
  - any word in progress is discarded
- Handshakes:
  - in_fire = valid_i && ready_o
  - out_fire = valid_o && ready_i
  - valid_o/unpacked_o/last_o are stable while valid_o && !ready_i
  - valid_o never drops without out_fire
- Count handling:
  - count_i is captured on in_fire as eff_count
  - count_i == 0 or count_i > PackedNum is clamped to PackedNum
  - eff_count is always in 1..PackedNum
- State:
  - IDLE (busy=0) -> on in_fire -> EMIT: word, eff_count and last_i captured; index=0
  - EMIT, out_fire with index < eff_count-1: index increments
  - EMIT, out_fire with index == eff_count-1 (final element), and in_fire in the same cycle: new word loaded, index=0, stays EMIT
  - EMIT, final-element out_fire without in_fire: -> IDLE
- Element select for index k:
  - MsbFirst=0: slice [k*UnpackedWidth +: UnpackedWidth]
  - MsbFirst=1: slice [(PackedNum-1-k)*UnpackedWidth +: UnpackedWidth]
  - Bits outside the eff_count elements are ignored
- Outputs:
  - valid_o = busy
  - unpacked_o = selected slice, gated to 0 when !busy
  - last_o = busy && captured last_i && index == eff_count-1
- ready_o = !busy || (out_fire && index == eff_count-1). This is the only combinational input-to-output path (ready_i -> ready_o).
- Latency and throughput:
  - element 0 is valid the cycle after in_fire
  - with ready_i held high, exactly one element per cycle
  - no idle cycle between consecutive words
- No path from packed_i, count_i, last_i or valid_i to any output within the same cycle.

Test Plan:
- Reset, then packed_i=8'hE4, count_i=4, last_i=0, MsbFirst=0, ready_i=1 -> unpacked_o 0,1,2,3 on consecutive cycles; last_o=0 throughout; ready_o high on the cycle element 3 fires.
- Same word with MsbFirst=1 -> 3,2,1,0; then count_i=0 -> treated as 4 elements.
- packed_i=8'hE4, count_i=2, last_i=1 -> exactly 2 elements (0,1); last_o=1 only with element 1; then valid_o=0.
- Back-to-back 8'hE4 and 8'h1B, valid_i held high, ready_i=1 -> 0,1,2,3,3,2,1,0 in 8 consecutive cycles; second word accepted on the same edge element 3 fires; no bubble.
- ready_i toggled pseudo-randomly over 20 words with random count_i/last_i -> element sequence and last_o match the reference model; outputs held stable while stalled; no loss or duplication.
- rst_ni pulsed low asynchronously mid-word (after element 1) -> valid_o=0 and ready_o=1 immediately; the next word restarts at element 0.
